// File: rtl/toggle_monitor_if.sv
// toggle_monitor_if: reader snapshot handshake between a reader and toggle_monitor.
interface toggle_monitor_if #(parameter int CNT_W = 8);
  logic             rd_req;
  logic             rd_ack;
  logic [CNT_W-1:0] rd_data;
  modport master (output rd_req, input rd_ack, rd_data);
  modport slave  (input rd_req, output rd_ack, rd_data);
endinterface

// File: rtl/toggle_monitor.sv
// toggle_monitor: synchronises t_latch q, counts toggles, flags stalls, serves count snapshots.
module toggle_monitor #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            q_in,
  input  logic            clear,
  toggle_monitor_if.slave rd,
  output logic            rise,
  output logic            fall,
  output logic            sat,
  output logic            stall
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACK  = 1'b1;
  logic             s1_q, s2_q, s3_q, ev;
  logic [CNT_W-1:0] cnt_q, cnt_d, snap_q, snap_d;
  logic             sat_q, sat_d, stall_q, stall_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [0:0]       st_q, st_d;
  assign rise       = s2_q & ~s3_q;
  assign fall       = ~s2_q & s3_q;
  assign sat        = sat_q;
  assign stall      = stall_q;
  assign rd.rd_ack  = st_q;
  assign rd.rd_data = snap_q;
  // clear outranks a coincident edge, so the count restarts at 0 rather than 1
  always_comb begin
    ev      = rise | fall;
    cnt_d   = clear ? '0 : (ev && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    sat_d   = clear ? 1'b0 : sat_q | (&cnt_d);
    tmr_d   = (clear || ev) ? '0 : (tmr_q == TW'(TIMEOUT)) ? tmr_q : tmr_q + 1'b1;
    stall_d = tmr_d == TW'(TIMEOUT);
    st_d    = rd.rd_req ? ACK : IDLE;
    snap_d  = (st_q == IDLE && rd.rd_req) ? cnt_q : snap_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      tmr_q   <= '0;
      stall_q <= 1'b0;
      st_q    <= IDLE;
      snap_q  <= '0;
    end else begin
      s1_q    <= q_in;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      tmr_q   <= tmr_d;
      stall_q <= stall_d;
      st_q    <= st_d;
      snap_q  <= snap_d;
    end
  end
endmodule

// File: tb/tb_toggle_monitor.sv
// tb_toggle_monitor: directed + random stimulus against a sampled-history reference model,
// with snapshot reads checked by an independent scoreboard monitor.
module tb_toggle_monitor;
  localparam int CW   = 4;
  localparam int TO   = 16;
  localparam int MAXC = (1 << CW) - 1;
  logic clk = 1'b0, rst = 1'b0, q_in = 1'b0, clear = 1'b0;
  logic rise, fall, sat, stall;
  toggle_monitor_if #(.CNT_W(CW)) rd();
  toggle_monitor #(.CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .q_in(q_in), .clear(clear), .rd(rd),
    .rise(rise), .fall(fall), .sat(sat), .stall(stall)
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  int hist[$];
  int snaps[$];
  int m_cnt, m_idle, m_sat, m_ack;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    hist = '{0, 0, 0};
    m_cnt = 0; m_idle = 0; m_sat = 0; m_ack = 0;
    snaps.delete();
  endtask
  // hist[0] is the newest q_in value seen at a clock edge; edges show up two samples later
  task automatic model_step(int qi, int clr, int req);
    int ev;
    ev = hist[1] != hist[2];
    if (!m_ack && req) snaps.push_back(m_cnt);
    m_ack = req;
    if (clr) begin
      m_cnt = 0; m_idle = 0; m_sat = 0;
    end else begin
      if (ev) m_cnt = (m_cnt < MAXC) ? m_cnt + 1 : MAXC;
      m_idle = ev ? 0 : (m_idle < TO ? m_idle + 1 : TO);
      if (m_cnt == MAXC) m_sat = 1;
    end
    hist.push_front(qi);
    void'(hist.pop_back());
  endtask
  task automatic tick(int qi, int clr, int req);
    q_in = qi[0]; clear = clr[0]; rd.rd_req = req[0];
    @(posedge clk);
    model_step(qi, clr, req);
    @(negedge clk);
    chk("rise", rise, (hist[1] && !hist[2]) ? 1 : 0);
    chk("fall", fall, (!hist[1] && hist[2]) ? 1 : 0);
    chk("sat", sat, m_sat);
    chk("stall", stall, (m_idle == TO) ? 1 : 0);
    chk("rd_ack", rd.rd_ack, m_ack);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_rd_ack", rd.rd_ack, 0);
    chk("rst_rd_data", rd.rd_data, 0);
    chk("rst_rise", rise, 0);
    chk("rst_fall", fall, 0);
    chk("rst_sat", sat, 0);
    chk("rst_stall", stall, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    bit seen = 0;
    int exp_snap = 0;
    forever begin
      @(negedge clk);
      if (rst) seen = 0;
      else begin
        if (rd.rd_ack) begin
          if (!seen) begin
            if (snaps.size() == 0) begin
              total++; bad++; exp_snap = -1;
              $display("FAIL snapshot: rd_ack raised with no snapshot expected at %0t", $time);
            end else exp_snap = snaps.pop_front();
          end
          chk("rd_data", rd.rd_data, exp_snap);
        end
        seen = rd.rd_ack;
      end
    end
  end
  initial begin
    int v, mode, req;
    rd.rd_req = 1'b0;
    model_reset();
    #2;
    do_reset();
    repeat (20) tick(0, 0, 0);
    for (int i = 0; i < 4; i++) repeat (5) tick((i % 2 == 0) ? 1 : 0, 0, 0);
    repeat (3) tick(0, 0, 1);
    repeat (2) tick(0, 0, 0);
    tick(0, 1, 0);
    for (int i = 0; i < 3; i++) repeat (3) tick((i % 2 == 0) ? 1 : 0, 0, 0);
    repeat (3) tick(1, 0, 0);
    tick(1, 0, 1);
    for (int i = 0; i < 3; i++) repeat (3) tick((i % 2 == 0) ? 0 : 1, 0, 1);
    repeat (3) tick(0, 0, 1);
    tick(0, 0, 0);
    repeat (3) tick(0, 0, 1);
    tick(0, 0, 0);
    v = 0;
    for (int i = 0; i < 20; i++) begin
      v = 1 - v;
      repeat (2) tick(v, 0, 0);
    end
    repeat (4) tick(v, 0, 0);
    repeat (2) tick(v, 0, 1);
    tick(v, 0, 0);
    tick(v, 1, 0);
    repeat (2) tick(v, 0, 1);
    tick(v, 0, 0);
    v = 1 - v;
    tick(v, 0, 0);
    tick(v, 0, 0);
    tick(v, 1, 0);
    repeat (2) tick(v, 0, 1);
    tick(v, 0, 0);
    mode = 0; req = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) mode = $urandom_range(0, 2);
      if (mode == 0 && $urandom_range(0, 1) == 0) v = 1 - v;
      if (mode == 1 && $urandom_range(0, 7) == 0) v = 1 - v;
      if ($urandom_range(0, 3) == 0) req = 1 - req;
      tick(v, ($urandom_range(0, 63) == 0) ? 1 : 0, req);
    end
    tick(1, 0, 1);
    tick(1, 0, 1);
    #2;
    do_reset();
    repeat (10) tick(1, 0, 0);
    repeat (2) tick(1, 0, 1);
    tick(1, 0, 0);
    repeat (25) tick(1, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/toggle_monitor.md
# toggle_monitor

- Downstream consumer of the `t_latch` output `q`.
- Synchronises the latch output into the system clock domain and detects its rising and falling edges.
- Counts toggles in a saturating counter and flags a stall when no toggle occurs within a programmable window.
- Offers the count to a reader through a req/ack snapshot handshake; this is the observation point for toggle activity in the latch stage.

## Interface
- `CNT_W`, 8: toggle counter and `rd_data` width (≥2).
- `TIMEOUT`, 16: toggle-free cycles before `stall` asserts (≥2); idle timer width is `$clog2(TIMEOUT+1)`.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `q_in`  in  1  `t_latch` `q` output; asynchronous to `clk`.
- `clear`  in  1  synchronous clear of the count, `sat`, `stall` and the idle timer.
- `rd_req`  in  1  reader request level.
- `rd_ack`  out  1  snapshot valid / acknowledge.
- `rd_data`  out  CNT_W  count snapshot.
- `rise`  out  1  one-cycle pulse on a synchronised 0→1 transition.
- `fall`  out  1  one-cycle pulse on a synchronised 1→0 transition.
- `sat`  out  1  sticky: counter reached all-ones.
- `stall`  out  1  idle timer reached `TIMEOUT`.

## Operation
- **Synchroniser**
  - Three-flop chain: `s1` ← `q_in`, `s2` ← `s1`, `s3` ← `s2`.
  - `rise` = `s2 & ~s3`; `fall` = `~s2 & s3`. Both are combinational from flops.
  - `edge` = `rise | fall`.
- **Counter**
  - On `edge`, `cnt` ← `cnt+1` unless `cnt` is all-ones, in which case it holds.
  - `sat` sets the cycle `cnt` becomes all-ones and holds until `clear` or `rst`.
- **Idle timer**
  - Resets to 0 on `edge`; otherwise increments, stopping at `TIMEOUT`.
  - `stall` = (timer == `TIMEOUT`), registered with the timer.
  - `stall` drops on the edge after an `edge` pulse.
- **Clear**
  - On `clear`, `cnt`, `sat`, timer and `stall` all go to 0.
  - `clear` has priority over a simultaneous `edge`: `cnt` = 0, not 1.
  - The synchroniser chain is not cleared.
- **Read FSM**, states IDLE and ACK:
  - IDLE, `rd_req`=1: capture `rd_data` ← `cnt` (the pre-update value of this cycle) and go to ACK.
  - ACK: `rd_ack`=1 and `rd_data` is frozen. Stay while `rd_req`=1.
  - ACK, `rd_req`=0: go to IDLE; `rd_ack` is 0 the following cycle.
  - `rd_data` holds its last snapshot in IDLE.
  - Counting, `clear` and saturation continue during ACK and do not alter the snapshot.
  - A new snapshot requires `rd_req` to drop for at least one cycle.

## Timing
- **Reset values** (asynchronous): `s1`/`s2`/`s3`=0, `cnt`=0, timer=0, FSM=IDLE. All outputs (`rd_ack`, `rd_data`, `rise`, `fall`, `sat`, `stall`) are 0.
- **Edge latency**: a `q_in` change first sampled by `s1` at edge k produces `rise`/`fall` high during the cycle after edge k+1, for exactly one cycle. The counter increments at edge k+2.
- **After reset release with `q_in`=1**: one `rise` and one count occur; this is required behaviour.
- **Pulse rate**: `q_in` pulses shorter than one `clk` period may be missed. No glitch filtering is performed.
- **Read handshake**: `rd_req` high at edge n gives `rd_ack`=1 and a valid `rd_data` after edge n. `rd_req` low at edge m gives `rd_ack`=0 after edge m.
- **Stall latency**: `stall` asserts exactly `TIMEOUT` cycles after the last `edge` cycle (or after reset/`clear`).
- **Reset mid-read**: `rd_ack` drops immediately and `rd_data` goes to 0.

## Test plan
- **Reset then single toggle**: reset, then `q_in` 0→1 → `rise` is a single one-cycle pulse 2 cycles later; `cnt`=1; `fall`=0.
- **Four alternating toggles** spaced 5 cycles apart → 2 `rise` and 2 `fall` pulses; snapshot read returns `rd_data`=4.
- **Saturation** with `CNT_W`=4: 20 toggles → `cnt` holds at 15 and `sat`=1; then `clear` → `cnt`=0, `sat`=0.
- **Stall** with `TIMEOUT`=16: no toggles after reset → `stall`=1 at cycle 16 and stays; one toggle → `stall`=0 the cycle after `rise`.
- **Read during counting**: `rd_req` held high with snapshot 3, toggles continue to `cnt`=6 → `rd_data` stays 3. Drop `rd_req` for one cycle and raise it again → `rd_data`=6.
- **Simultaneous events**:
  - `clear` in the same cycle as a `rise` → `cnt`=0.
  - Asynchronous `rst` pulse during ACK → `rd_ack` and `rd_data` go to 0 immediately.
